// File: rtl/supercar_pkg.sv
// Shared types and constants for the supercar sweep controller.
package supercar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    UP   = 2'd2,
    DN   = 2'd3
  } state_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Signed compare keeps the check meaningful even when lo is zero.
  function automatic logic in_range(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/supercar_if.sv
// Controller <-> counter/host signal bundle; slave is the controller side.
interface supercar_if #(
  parameter int unsigned CNT_W = 4
);
  localparam int unsigned LED_W = 32'd1 << CNT_W;

  logic             start;
  logic             stop;
  logic [CNT_W-1:0] cnt;
  logic             en;
  logic             d_nu;
  logic             pl;
  logic [CNT_W-1:0] pin;
  logic             busy;
  logic [LED_W-1:0] led;

  modport master (
    output start, stop, cnt,
    input  en, d_nu, pl, pin, busy, led
  );

  modport slave (
    input  start, stop, cnt,
    output en, d_nu, pl, pin, busy, led
  );
endinterface

// File: rtl/supercar_ctrl_tick_gen.sv
// Step-rate prescaler: one-cycle tick every DIV cycles while run is high.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);
  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] q;

  assign tick = run && (q == W'(DIV - 1));

  // Held at zero whenever not running so every sweep starts a full period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              q <= '0;
    else if (clr || !run)  q <= '0;
    else if (tick)         q <= '0;
    else                   q <= q + W'(1);
  end
endmodule

// File: rtl/supercar_ctrl.sv
// Sequences an external up/down loadable counter into a back-and-forth LED sweep.
module supercar_ctrl
  import supercar_pkg::*;
#(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned LO    = 0,
  parameter int unsigned HI    = 7,
  parameter int unsigned DIV   = 4
) (
  input  logic       clk,
  input  logic       rst,
  supercar_if.slave  bus
);
  localparam int unsigned      LED_W = 32'd1 << CNT_W;
  localparam logic [CNT_W-1:0] LO_V  = CNT_W'(LO);
  localparam logic [CNT_W-1:0] HI_V  = CNT_W'(HI);

  state_e state, state_nxt;
  logic   tick, run, clr, in_rng;
  logic   en, pl, d_nu, busy;

  assign run    = (state == UP) || (state == DN);
  assign clr    = (state == LOAD);
  assign in_rng = in_range(int'(bus.cnt), int'(LO), int'(HI));

  tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .run  (run),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and Moore outputs; en additionally masked at the sweep ends.
  always_comb begin
    state_nxt = state;
    en        = 1'b0;
    pl        = 1'b0;
    d_nu      = DIR_UP;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) state_nxt = LOAD;
      end
      LOAD: begin
        pl        = 1'b1;
        busy      = 1'b1;
        state_nxt = bus.stop ? IDLE : UP;
      end
      UP: begin
        busy = 1'b1;
        en   = tick && (bus.cnt != HI_V);
        if (bus.stop)             state_nxt = IDLE;
        else if (!in_rng)         state_nxt = LOAD;
        else if (bus.cnt == HI_V) state_nxt = DN;
      end
      DN: begin
        busy = 1'b1;
        d_nu = DIR_DN;
        en   = tick && (bus.cnt != LO_V);
        if (bus.stop)             state_nxt = IDLE;
        else if (!in_rng)         state_nxt = LOAD;
        else if (bus.cnt == LO_V) state_nxt = UP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.en   = en;
  assign bus.pl   = pl;
  assign bus.d_nu = d_nu;
  assign bus.busy = busy;
  assign bus.pin  = LO_V;
  assign bus.led  = busy ? (LED_W'(1) << bus.cnt) : '0;
endmodule

// File: tb/tb_supercar_ctrl.sv
// Scoreboard bench: two controllers (DIV=4 and DIV=1) each driving a modelled counter.
module tb_supercar_ctrl;
  logic clk;
  logic rst;
  logic [3:0] c4, c1;
  int n_chk, n_pass;
  int exp_q[$];

  supercar_if #(.CNT_W(4)) b4();
  supercar_if #(.CNT_W(4)) b1();

  supercar_ctrl #(.CNT_W(4), .LO(0), .HI(7), .DIV(4)) u_div4 (
    .clk (clk), .rst (rst), .bus (b4)
  );
  supercar_ctrl #(.CNT_W(4), .LO(0), .HI(7), .DIV(1)) u_div1 (
    .clk (clk), .rst (rst), .bus (b1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  // One clock: counters act on the controls present before the edge, cnt updates just after it.
  task automatic cyc();
    logic p4, e4, d4, p1, e1, d1;
    p4 = b4.pl; e4 = b4.en; d4 = b4.d_nu;
    p1 = b1.pl; e1 = b1.en; d1 = b1.d_nu;
    @(posedge clk);
    #1;
    if (p4)      c4 = 4'd0;
    else if (e4) c4 = d4 ? c4 - 4'd1 : c4 + 4'd1;
    if (p1)      c1 = 4'd0;
    else if (e1) c1 = d1 ? c1 - 4'd1 : c1 + 4'd1;
    b4.cnt = c4;
    b1.cnt = c1;
    #1;
  endtask

  task automatic push_run(input int v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic drain(input string tag, input bit use1);
    int e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, use1 ? 32'(b1.cnt) : 32'(b4.cnt), 32'(e));
      check({tag, "_led"}, use1 ? 32'(b1.led) : 32'(b4.led), 32'(1) << e);
      cyc();
    end
  endtask

  initial begin
    int guard;
    int e;
    n_chk = 0; n_pass = 0;
    rst = 1'b0;
    b4.start = 1'b0; b4.stop = 1'b0; b1.start = 1'b0; b1.stop = 1'b0;
    c4 = 4'd0; c1 = 4'd0; b4.cnt = 4'd0; b1.cnt = 4'd0;
    #3;
    check("rst_en",   32'(b4.en),   32'd0);
    check("rst_pl",   32'(b4.pl),   32'd0);
    check("rst_dnu",  32'(b4.d_nu), 32'd0);
    check("rst_busy", 32'(b4.busy), 32'd0);
    check("rst_led",  32'(b4.led),  32'd0);
    check("rst_pin",  32'(b4.pin),  32'd0);
    #4 rst = 1'b1;
    cyc();

    // DIV=4 full sweep: every position held 4 cycles, ends included
    b4.start = 1'b1;
    cyc();
    check("load_pl", 32'(b4.pl), 32'd1);
    b4.start = 1'b0;
    cyc();
    check("up_pl", 32'(b4.pl), 32'd0);
    for (int v = 0; v <= 7; v++) push_run(v, 4);
    for (int v = 6; v >= 0; v--) push_run(v, 4);
    push_run(1, 4);
    drain("sweep4", 1'b0);

    // stop while moving up at 5, on the tick cycle
    guard = 0;
    while (b4.cnt != 4'd5 && guard < 40) begin cyc(); guard++; end
    check("reach5", 32'(b4.cnt), 32'd5);
    cyc(); cyc(); cyc();
    check("tick_en",  32'(b4.en),   32'd1);
    check("tick_dir", 32'(b4.d_nu), 32'd0);
    b4.stop = 1'b1;
    cyc();
    b4.stop = 1'b0;
    check("stop_en",   32'(b4.en),   32'd0);
    check("stop_busy", 32'(b4.busy), 32'd0);
    check("stop_led",  32'(b4.led),  32'd0);
    check("stop_cnt",  32'(b4.cnt),  32'd6);
    cyc(); cyc();
    check("frozen_cnt", 32'(b4.cnt), 32'd6);

    // restart reloads LO; a start pulse mid-sweep is ignored
    b4.start = 1'b1;
    cyc();
    check("reload_pl", 32'(b4.pl), 32'd1);
    b4.start = 1'b0;
    cyc();
    push_run(0, 4); push_run(1, 4); push_run(2, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      check("restart_cnt", 32'(b4.cnt), 32'(e));
      check("restart_pl",  32'(b4.pl),  32'd0);
      b4.start = (i == 1);
      cyc();
    end
    b4.start = 1'b0;

    // counter corrupted to 12 during UP: resynchronising load, then UP from 0
    c4 = 4'd12; b4.cnt = 4'd12;
    #1;
    check("oor_busy", 32'(b4.busy), 32'd1);
    cyc();
    check("oor_pl",  32'(b4.pl),  32'd1);
    check("oor_pin", 32'(b4.pin), 32'd0);
    cyc();
    push_run(0, 4); push_run(1, 1);
    drain("resync", 1'b0);

    // stop, then start+stop together in IDLE stays idle
    b4.stop = 1'b1;
    cyc();
    check("stop2_busy", 32'(b4.busy), 32'd0);
    b4.start = 1'b1;
    cyc();
    check("both_pl",   32'(b4.pl),   32'd0);
    check("both_busy", 32'(b4.busy), 32'd0);
    cyc();
    check("both_busy2", 32'(b4.busy), 32'd0);
    b4.start = 1'b0; b4.stop = 1'b0;
    cyc();

    // DIV=1: ends dwell 2 cycles, interior 1 cycle
    b1.start = 1'b1;
    cyc();
    check("d1_pl", 32'(b1.pl), 32'd1);
    b1.start = 1'b0;
    cyc();
    for (int v = 0; v <= 7; v++) push_run(v, 1);
    push_run(7, 1);
    for (int v = 6; v >= 0; v--) push_run(v, 1);
    push_run(0, 1);
    for (int v = 1; v <= 7; v++) push_run(v, 1);
    push_run(7, 1); push_run(6, 1); push_run(5, 1);
    drain("sweep1", 1'b1);
    check("d1_dir", 32'(b1.d_nu), 32'd1);

    // asynchronous reset mid-DN, between edges
    #2 rst = 1'b0;
    #1;
    check("arst_en",   32'(b1.en),   32'd0);
    check("arst_pl",   32'(b1.pl),   32'd0);
    check("arst_dnu",  32'(b1.d_nu), 32'd0);
    check("arst_busy", 32'(b1.busy), 32'd0);
    check("arst_led",  32'(b1.led),  32'd0);
    #1 rst = 1'b1;
    cyc(); cyc();
    check("post_busy", 32'(b1.busy), 32'd0);
    check("post_cnt",  32'(b1.cnt),  32'd4);
    b1.start = 1'b1;
    cyc();
    check("post_pl", 32'(b1.pl), 32'd1);
    b1.start = 1'b0;
    cyc();
    check("post_load", 32'(b1.cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
